// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, WB control bit
// positions, byte-enable patterns and the timeout counter width.
package pipe_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int BE_W = 4;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;
  localparam logic [BE_W-1:0] BE_HI   = 4'b1100;
  localparam logic [BE_W-1:0] BE_LO   = 4'b0011;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store-data replication, byte enables and
// halfword load selection with sign extension.
module mem_lane_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              w_h,
  input  logic              addr_hi,
  input  logic [DATA_W-1:0] di,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata_ext
);

  localparam int HALF_W = DATA_W / 2;

  logic signed [HALF_W-1:0] half_sel;

  function automatic logic signed [DATA_W-1:0] sext_half(input logic signed [HALF_W-1:0] h);
    return {{HALF_W{h[HALF_W-1]}}, h};
  endfunction

  always_comb begin
    half_sel  = addr_hi ? rdata[DATA_W-1:HALF_W] : rdata[HALF_W-1:0];
    wdata     = di;
    be        = BE_WORD;
    rdata_ext = rdata;
    if (!w_h) begin
      wdata     = {2{di[HALF_W-1:0]}};
      be        = addr_hi ? BE_HI : BE_LO;
      rdata_ext = sext_half(half_sel);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack bus, stalls upstream
// while an access is outstanding and owns the MEM->WB pipeline register.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              reloj,
  input  logic              resetMEM,
  input  logic              MEM_RD,
  input  logic              MEM_WR,
  input  logic              w_h,
  input  logic [1:0]        ctrl_WB_mem,
  input  logic [DATA_W-1:0] DIR,
  input  logic [DATA_W-1:0] DI,
  input  logic [REG_W-1:0]  Y_MUX_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_mem,
  output logic              bus_err,
  output logic [1:0]        ctrl_WB_wb,
  output logic [DATA_W-1:0] RD_DATA_wb,
  output logic [DATA_W-1:0] ALU_wb,
  output logic [REG_W-1:0]  Y_MUX_wb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic              mem_op;
  logic              both_op;
  logic              misalign;
  logic              legal_op;
  logic              illegal_op;
  logic              in_access;
  logic              at_limit;
  logic [DATA_W-1:0] lane_wdata;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] load_data;

  assign mem_op     = MEM_RD ^ MEM_WR;
  assign both_op    = MEM_RD & MEM_WR;
  assign misalign   = mem_op & w_h & (DIR[1:0] != 2'b00);
  assign legal_op   = mem_op & ~misalign;
  assign illegal_op = both_op | misalign;
  assign in_access  = (state == ACCESS);
  assign at_limit   = (cnt == CNT_MAX);

  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .w_h       (w_h),
    .addr_hi   (DIR[1]),
    .di        (DI),
    .rdata     (mem_rdata),
    .wdata     (lane_wdata),
    .be        (lane_be),
    .rdata_ext (load_data)
  );

  // Request depends only on state, counter and the held EX_MEM fields, never on
  // mem_ack; holding reset also forces the bus quiet while inputs still show an op.
  always_comb begin
    mem_req   = ~resetMEM & ((~in_access & legal_op) | (in_access & ~at_limit));
    stall_mem = ~resetMEM & ((~in_access & legal_op) | (in_access & ~mem_ack & ~at_limit));
    mem_we    = mem_req & MEM_WR;
    mem_addr  = mem_req ? {DIR[DATA_W-1:2], 2'b00} : '0;
    mem_wdata = mem_req ? lane_wdata : '0;
    mem_be    = mem_req ? lane_be : '0;
  end

  // MEM -> WB stage boundary
  always_ff @(posedge reloj or posedge resetMEM) begin
    if (resetMEM) begin
      state      <= IDLE;
      cnt        <= '0;
      bus_err    <= 1'b0;
      ctrl_WB_wb <= '0;
      RD_DATA_wb <= '0;
      ALU_wb     <= '0;
      Y_MUX_wb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (illegal_op) begin
            bus_err    <= 1'b1;
            ctrl_WB_wb <= '0;
          end else if (legal_op) begin
            state      <= ACCESS;
            cnt        <= '0;
            ctrl_WB_wb <= '0;
          end else begin
            ctrl_WB_wb <= ctrl_WB_mem;
            RD_DATA_wb <= '0;
            ALU_wb     <= DIR;
            Y_MUX_wb   <= Y_MUX_mem;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state      <= IDLE;
            ctrl_WB_wb <= ctrl_WB_mem;
            RD_DATA_wb <= MEM_RD ? load_data : '0;
            ALU_wb     <= DIR;
            Y_MUX_wb   <= Y_MUX_mem;
          end else if (at_limit) begin
            state      <= IDLE;
            bus_err    <= 1'b1;
            ctrl_WB_wb <= '0;
          end else begin
            cnt        <= cnt + 1'b1;
            ctrl_WB_wb <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed bench for mem_access_stage against a
// transaction-level reference model (cycle counts and lane arithmetic).
module tb_mem_access_stage;

  logic        reloj = 1'b0;
  logic        resetMEM;
  logic        MEM_RD, MEM_WR, w_h;
  logic [1:0]  ctrl_WB_mem;
  logic [31:0] DIR, DI;
  logic [4:0]  Y_MUX_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_mem, bus_err;
  logic [1:0]  ctrl_WB_wb;
  logic [31:0] RD_DATA_wb, ALU_wb;
  logic [4:0]  Y_MUX_wb;

  int checks = 0;
  int errors = 0;
  logic err_model = 1'b0;

  always #5 reloj = ~reloj;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(255)) dut (
    .reloj       (reloj),
    .resetMEM    (resetMEM),
    .MEM_RD      (MEM_RD),
    .MEM_WR      (MEM_WR),
    .w_h         (w_h),
    .ctrl_WB_mem (ctrl_WB_mem),
    .DIR         (DIR),
    .DI          (DI),
    .Y_MUX_mem   (Y_MUX_mem),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_mem   (stall_mem),
    .bus_err     (bus_err),
    .ctrl_WB_wb  (ctrl_WB_wb),
    .RD_DATA_wb  (RD_DATA_wb),
    .ALU_wb      (ALU_wb),
    .Y_MUX_wb    (Y_MUX_wb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    MEM_RD = 1'b0;
    MEM_WR = 1'b0;
    mem_ack = 1'b0;
  endtask

  // One instruction through the stage. ack_at = cycle index (counting the
  // request cycle as 0) on which the memory acknowledges; 0 means never.
  task automatic do_op(input logic rd, input logic wr, input logic wh,
                       input logic [1:0] ctrl, input logic [31:0] dir,
                       input logic [31:0] di, input logic [4:0] rdst,
                       input int ack_at, input logic [31:0] rdata);
    logic isop, illegal, legal;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;
    logic [15:0] half;
    int nreq, nstall, nbub, nhold, end_cyc;
    isop    = rd ^ wr;
    illegal = (rd & wr) | (isop & wh & (dir[1:0] != 2'b00));
    legal   = isop & ~illegal;
    exp_addr = dir - (dir % 4);
    if (wh) begin
      exp_wdata = di;
      exp_be    = 4'hF;
    end else begin
      exp_wdata = (di % 65536) * 65537;
      exp_be    = dir[1] ? 4'hC : 4'h3;
    end
    if (!rd) exp_rd = 32'h0;
    else if (wh) exp_rd = rdata;
    else begin
      half   = dir[1] ? rdata[31:16] : rdata[15:0];
      exp_rd = (half >= 16'h8000) ? (32'(half) - 32'h10000) : 32'(half);
    end

    @(negedge reloj);
    MEM_RD = rd; MEM_WR = wr; w_h = wh; ctrl_WB_mem = ctrl;
    DIR = dir; DI = di; Y_MUX_mem = rdst; mem_ack = 1'b0;
    mem_rdata = $urandom;
    #1;
    if (!legal) begin
      chk("idle_req", mem_req, 0);
      chk("idle_stall", stall_mem, 0);
      @(negedge reloj);
      drive_nop();
      #1;
      if (illegal) begin
        err_model = 1'b1;
        chk("err_bubble", ctrl_WB_wb, 0);
      end else begin
        chk("alu_ctrl", ctrl_WB_wb, ctrl);
        chk("alu_data", ALU_wb, dir);
        chk("alu_rd", Y_MUX_wb, rdst);
        chk("alu_rdata", RD_DATA_wb, 0);
      end
      chk("bus_err", bus_err, err_model);
      return;
    end

    chk("req_addr", mem_addr, exp_addr);
    chk("req_we", mem_we, wr);
    chk("req_wdata", mem_wdata, exp_wdata);
    chk("req_be", mem_be, exp_be);
    nreq = 0; nstall = 0; nbub = 0; nhold = 0;
    end_cyc = (ack_at != 0) ? ack_at : 256;
    for (int cyc = 0; cyc <= 300; cyc++) begin
      if (cyc > 0) @(negedge reloj);
      mem_ack   = (ack_at != 0 && cyc == ack_at);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      if (mem_req) nreq++;
      if (stall_mem) nstall++;
      if (cyc > 0 && ctrl_WB_wb != 2'b00) nbub++;
      if (mem_req && (mem_addr != exp_addr || mem_be != exp_be ||
                      mem_wdata != exp_wdata || mem_we != wr)) nhold++;
      if (cyc == end_cyc) break;
    end
    chk("req_cycles", nreq, (ack_at != 0) ? ack_at + 1 : 256);
    chk("stall_cycles", nstall, (ack_at != 0) ? ack_at : 256);
    chk("bubbles", nbub, 0);
    chk("bus_held", nhold, 0);

    @(negedge reloj);
    drive_nop();
    #1;
    chk("post_req", mem_req, 0);
    chk("post_stall", stall_mem, 0);
    if (ack_at != 0) begin
      chk("wb_ctrl", ctrl_WB_wb, ctrl);
      chk("wb_rdata", RD_DATA_wb, exp_rd);
      chk("wb_alu", ALU_wb, dir);
      chk("wb_rd", Y_MUX_wb, rdst);
    end else begin
      err_model = 1'b1;
      chk("timeout_bubble", ctrl_WB_wb, 0);
    end
    chk("bus_err", bus_err, err_model);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    resetMEM = 1'b1;
    drive_nop();
    w_h = 1'b1; ctrl_WB_mem = 2'b00; DIR = '0; DI = '0; Y_MUX_mem = '0; mem_rdata = '0;
    #2;
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_mem, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_ctrl", ctrl_WB_wb, 0);
    chk("rst_alu", ALU_wb, 0);
    chk("rst_rdata", RD_DATA_wb, 0);
    chk("rst_rd", Y_MUX_wb, 0);
    @(negedge reloj);
    resetMEM = 1'b0;
    #1;
    chk("rel_req", mem_req, 0);

    do_op(1'b0, 1'b0, 1'b1, 2'b10, 32'h10, 32'h0, 5'd5, 0, 32'h0);
    do_op(1'b1, 1'b0, 1'b1, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 1'b0, 2'b00, 32'h202, 32'h1234ABCD, 5'd0, 1, 32'h0);
    do_op(1'b1, 1'b0, 1'b0, 2'b11, 32'h202, 32'h0, 5'd9, 2, 32'h80010000);
    do_op(1'b1, 1'b0, 1'b0, 2'b11, 32'h55, 32'h0, 5'd3, 1, 32'h1234F00F);

    // Ack while idle must be ignored
    @(negedge reloj);
    MEM_RD = 1'b0; MEM_WR = 1'b0; ctrl_WB_mem = 2'b10; DIR = 32'h77; Y_MUX_mem = 5'd4;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("idle_ack_req", mem_req, 0);
    @(negedge reloj);
    mem_ack = 1'b0;
    #1;
    chk("idle_ack_rdata", RD_DATA_wb, 0);
    chk("idle_ack_ctrl", ctrl_WB_wb, 2'b10);
    do_op(1'b1, 1'b0, 1'b1, 2'b11, 32'h400, 32'h0, 5'd6, 1, 32'h0BADF00D);

    for (int n = 0; n < 40; n++) begin
      int kind;
      logic rd, wr;
      kind = $urandom_range(0, 9);
      rd = (kind >= 3 && kind <= 5) || kind == 9;
      wr = (kind >= 6);
      do_op(rd, wr, 1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom,
            5'($urandom), $urandom_range(1, 6), $urandom);
    end

    do_op(1'b1, 1'b0, 1'b1, 2'b11, 32'h101, 32'h0, 5'd1, 1, 32'h0);
    do_op(1'b1, 1'b1, 1'b1, 2'b11, 32'h100, 32'h0, 5'd1, 1, 32'h0);
    do_op(1'b1, 1'b0, 1'b1, 2'b11, 32'h180, 32'h0, 5'd2, 0, 32'h0);

    // Reset in the middle of an access
    @(negedge reloj);
    MEM_RD = 1'b1; MEM_WR = 1'b0; w_h = 1'b1; ctrl_WB_mem = 2'b11; DIR = 32'h300;
    Y_MUX_mem = 5'd8; mem_ack = 1'b0;
    @(negedge reloj);
    @(negedge reloj);
    #1;
    chk("pre_rst_req", mem_req, 1);
    #1;
    resetMEM = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", stall_mem, 0);
    chk("mid_rst_err", bus_err, 0);
    chk("mid_rst_alu", ALU_wb, 0);
    chk("mid_rst_ctrl", ctrl_WB_wb, 0);
    err_model = 1'b0;
    drive_nop();
    @(negedge reloj);
    resetMEM = 1'b0;
    do_op(1'b1, 1'b0, 1'b1, 2'b11, 32'h300, 32'h0, 5'd8, 2, 32'h13579BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
